// File: rtl/iter_multiplier.sv
// Iterative radix-2^BITS_PER_CYCLE multiplier, unsigned or two's-complement operands.
// One operand pair in flight; the product is held in DONE until the consumer takes it.
module iter_multiplier #(
  parameter int unsigned INPUT_DATA_WIDTH  = 32,
  parameter int unsigned OUTPUT_DATA_WIDTH = 64,
  parameter int unsigned BITS_PER_CYCLE    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inputs_valid,
  output logic                         inputs_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]  in1,
  input  logic [INPUT_DATA_WIDTH-1:0]  in2,
  input  logic                         signed_mode,
  output logic [OUTPUT_DATA_WIDTH-1:0] out,
  output logic                         output_valid,
  input  logic                         output_ready,
  output logic                         busy
);

  localparam int unsigned W     = INPUT_DATA_WIDTH;
  localparam int unsigned PW    = OUTPUT_DATA_WIDTH;
  localparam int unsigned B     = BITS_PER_CYCLE;
  localparam int unsigned ITER  = W / B;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  if (W < 2) begin : g_bad_width
    $error("iter_multiplier: INPUT_DATA_WIDTH must be >= 2");
  end
  if (PW != 2 * W) begin : g_bad_out_width
    $error("iter_multiplier: OUTPUT_DATA_WIDTH must equal 2*INPUT_DATA_WIDTH");
  end
  if (B == 0 || (B & (B - 1)) != 0 || (W % B) != 0) begin : g_bad_digit
    $error("iter_multiplier: BITS_PER_CYCLE must be a power of 2 dividing INPUT_DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [W-1:0]     in1_mag, in2_mag;
  logic [PW-1:0]    mcand_sh;
  logic [W-1:0]     mplier_sh;
  logic             neg_q;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_sum;
  logic             last_iter;
  logic             accept;

  // -(-2^(W-1)) wraps back to 2^(W-1), which is exactly the unsigned magnitude wanted.
  always_comb begin
    in1_mag = (signed_mode && in1[W-1]) ? -in1 : in1;
    in2_mag = (signed_mode && in2[W-1]) ? -in2 : in2;
  end

  always_comb begin
    partial   = mcand_sh * {{(PW-B){1'b0}}, mplier_sh[B-1:0]};
    acc_sum   = acc + partial;
    last_iter = (cnt == CNT_W'(ITER - 1));
  end

  assign inputs_ready = (state == IDLE) || ((state == DONE) && output_ready);
  assign accept       = inputs_valid && inputs_ready;
  assign busy         = (state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (inputs_valid) state_next = BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (output_ready) state_next = inputs_valid ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shifting the multiplicand left one digit per cycle is equivalent to shifting each
  // partial product by cnt*B; signed_mode is captured as the final negate flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_sh     <= '0;
      mplier_sh    <= '0;
      neg_q        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      out          <= '0;
      output_valid <= 1'b0;
    end else if (accept) begin
      mcand_sh     <= {{(PW-W){1'b0}}, in1_mag};
      mplier_sh    <= in2_mag;
      neg_q        <= signed_mode && (in1[W-1] ^ in2[W-1]);
      acc          <= '0;
      cnt          <= '0;
      output_valid <= 1'b0;
    end else if (state == BUSY) begin
      acc       <= acc_sum;
      mcand_sh  <= mcand_sh << B;
      mplier_sh <= mplier_sh >> B;
      cnt       <= cnt + 1'b1;
      if (last_iter) begin
        out          <= neg_q ? -acc_sum : acc_sum;
        output_valid <= 1'b1;
      end
    end else if ((state == DONE) && output_ready) begin
      output_valid <= 1'b0;
    end
  end

endmodule
